uart_rx: RTL and testbench
==========================

# uart_rx

Serial receive stage of the UART; consumes the 16x oversampling `tick` from the baud generator and the asynchronous `rx` line. Detects start bits, samples each bit at its centre, and delivers one parallel byte per frame with a single-cycle valid strobe and error flags. Sits between the pad and the receive-side buffering/consumer logic.

## Interface
- `DATA_BITS`, 8: data bits per frame, LSB first; legal values 5–8.
- `SAMPLES`, 16: ticks per bit period; must match the baud generator setting.
- `clk` input 1: system clock. One clock; reset is asynchronous and active-low.
- `reset` input 1: asynchronous, active-low reset.
- `tick` input 1: one-`clk` pulse, `SAMPLES` pulses per bit period.
- `rx` input 1: asynchronous serial line; idle high.
- `data` output `DATA_BITS`: last good received word; holds until the next good frame.
- `valid` output 1: one-`clk` pulse when `data` updates.
- `framing_err` output 1: one-`clk` pulse when the stop bit is sampled low.
- `busy` output 1: high whenever the state is not IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. All logic uses the synchronized `rx_s`.
- The sample counter `s_cnt` is `$clog2(SAMPLES)` bits wide and the bit counter `b_cnt` is 3 bits wide. Both advance only on `clk` edges where `tick`=1.
- State machine:
  - IDLE: when `rx_s`=0, go to START with `s_cnt`=0. `tick` is not required.
  - START: on a tick with `s_cnt`=`SAMPLES/2-1`, check `rx_s`. If 0, go to DATA with `s_cnt`=0 and `b_cnt`=0. If 1, treat it as a glitch and return to IDLE with no flags. Otherwise increment `s_cnt`.
  - DATA: on a tick with `s_cnt`=`SAMPLES-1`, shift `rx_s` into the MSB of the shift register (right shift), clear `s_cnt`, and increment `b_cnt`. After the `DATA_BITS`th sample, go to STOP (or PARITY, see Configuration).
  - STOP: on a tick with `s_cnt`=`SAMPLES-1`, check `rx_s`. If 1, load `data` and pulse `valid`. If 0, pulse `framing_err` and leave `data` unchanged. Go to IDLE in both cases.
- Returning to IDLE at mid-stop lets the block accept back-to-back frames with no idle gap.
- `valid` and `framing_err` are never high in the same cycle.

## Timing
- Reset values: state IDLE, `data`=0, `valid`=0, `framing_err`=0, `busy`=0, counters 0, synchronizer flops 1.
- Reset asserted mid-frame aborts the frame immediately. No flags are raised after reset is released.
- `valid` and `framing_err` are registered. They go high in the `clk` cycle after the tick edge that samples the stop bit, and stay high for exactly one cycle.
- Latency from the `rx` falling edge to START: 2–3 `clk` cycles (synchronizer).
- `busy` rises in the cycle after IDLE→START and falls together with the `valid`/`framing_err` pulse.
- A `tick` arriving in the same cycle as the `rx_s` falling edge is not counted. The START count begins on the next tick.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Adds a PARITY state between DATA and STOP. It samples the parity bit at mid-bit.
  - Adds output `parity_err`, 1 bit, reset 0.
  - Even parity is required: XOR of the data bits and the parity bit must be 0.
  - On a parity mismatch with a good stop bit, `parity_err` pulses in the `valid` cycle. `data` still updates and `valid` still pulses.
- `UART_RX_PARITY_EN` undefined: no PARITY state and no `parity_err` port. The frame is start + `DATA_BITS` + stop.

## Structure
- Shared package `uart_pkg`:
  - State enum `rx_state_t` (IDLE, START, DATA, PARITY, STOP).
  - Constants `UART_SAMPLES`=16 and `UART_DATA_BITS`=8, shared with the baud generator and the future transmitter.
- One sub-module, `uart_sync2`: 2-flop synchronizer with reset value parameter `RESET_VAL`=1. Reused for other async inputs.

## Test plan
- Tick every 4 `clk`. Send 0xA5 with a good stop bit. Expect `data`=0xA5, `valid` high for one cycle, `framing_err`=0.
- Drive `rx` low for 3 ticks, then high. Expect `busy` to pulse and return to 0, with no `valid`/`framing_err`, and `data` unchanged.
- Send 0x3C with the stop bit low. Expect one `framing_err` pulse, no `valid`, and `data` still holding the previous value.
- Send 0x00 then 0xFF back-to-back with no idle bits. Expect two `valid` pulses with `data`=0x00 then 0xFF.
- Assert `reset` during bit 4 of a frame. Expect all outputs 0 at once, and no pulse once the rest of the frame completes after release.
- With `UART_RX_PARITY_EN`: send 0x01 with parity bit 0. Expect `data`=0x01, `valid`=1, and `parity_err`=1 in the same cycle. Send 0x01 with parity bit 1. Expect `parity_err`=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and frame constants
// common to the baud generator, receiver and transmitter.
package uart_pkg;

    localparam int UART_SAMPLES   = 16;
    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs; both flops
// reset to RESET_VAL so the output is quiet while reset is applied.
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled start detect, mid-bit sampling, byte output
// with valid/framing_err strobes. Define UART_RX_PARITY_EN for even parity.
//
// state  | meaning
// IDLE   | waiting for rx_s low (start edge)
// START  | counting to mid start bit, rejecting glitches
// DATA   | sampling DATA_BITS data bits, LSB first
// PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// STOP   | sampling the stop bit, then back to IDLE at mid-stop
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS,
    parameter int SAMPLES   = UART_SAMPLES
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 framing_err,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 busy
);

    localparam int SW = $clog2(SAMPLES);
    localparam logic [SW-1:0] S_MID  = SW'(SAMPLES / 2 - 1);
    localparam logic [SW-1:0] S_END  = SW'(SAMPLES - 1);
    localparam logic [2:0]    B_LAST = 3'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_t            state, state_nxt;
    logic [SW-1:0]        s_cnt, s_cnt_nxt;
    logic [2:0]           b_cnt, b_cnt_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic [DATA_BITS-1:0] data_nxt;
    logic                 valid_nxt;
    logic                 ferr_nxt;
`ifdef UART_RX_PARITY_EN
    logic                 par_bit, par_bit_nxt;
    logic                 perr_nxt;
`endif

    uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            s_cnt       <= '0;
            b_cnt       <= '0;
            shreg       <= '0;
            data        <= '0;
            valid       <= 1'b0;
            framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit     <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            s_cnt       <= s_cnt_nxt;
            b_cnt       <= b_cnt_nxt;
            shreg       <= shreg_nxt;
            data        <= data_nxt;
            valid       <= valid_nxt;
            framing_err <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
            par_bit     <= par_bit_nxt;
            parity_err  <= perr_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        s_cnt_nxt = s_cnt;
        b_cnt_nxt = b_cnt;
        shreg_nxt = shreg;
        data_nxt  = data;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_nxt = par_bit;
        perr_nxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                // Start edge needs no tick; counting begins on the next tick.
                if (!rx_s) begin
                    state_nxt = START;
                    s_cnt_nxt = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (s_cnt == S_MID) begin
                        s_cnt_nxt = '0;
                        b_cnt_nxt = '0;
                        state_nxt = rx_s ? IDLE : DATA;
                    end else begin
                        s_cnt_nxt = s_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (s_cnt == S_END) begin
                        s_cnt_nxt = '0;
                        shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
                        b_cnt_nxt = b_cnt + 3'd1;
                        if (b_cnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_nxt = PARITY;
`else
                            state_nxt = STOP;
`endif
                        end
                    end else begin
                        s_cnt_nxt = s_cnt + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (s_cnt == S_END) begin
                        s_cnt_nxt   = '0;
                        par_bit_nxt = rx_s;
                        state_nxt   = STOP;
                    end else begin
                        s_cnt_nxt = s_cnt + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (s_cnt == S_END) begin
                        s_cnt_nxt = '0;
                        state_nxt = IDLE;
                        if (rx_s) begin
                            data_nxt  = shreg;
                            valid_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                            perr_nxt  = ^{shreg, par_bit};
`endif
                        end else begin
                            ferr_nxt = 1'b1;
                        end
                    end else begin
                        s_cnt_nxt = s_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames, tick every 4 clk; expected
// strobes are queued by the stimulus and matched by a separate monitor.
module tb_uart_rx;

    localparam int BIT = 64;

    typedef struct {
        logic       is_err;
        logic [7:0] d;
        logic       perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       valid;
    logic       framing_err;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    uart_rx dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .rx          (rx),
        .data        (data),
        .valid       (valid),
        .framing_err (framing_err),
`ifdef UART_RX_PARITY_EN
        .parity_err  (parity_err),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        int div = 0;
        forever begin
            @(negedge clk);
            div  = (div == 3) ? 0 : div + 1;
            tick = (div == 3);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic is_err, input logic [7:0] d, input logic perr);
        exp_t e;
        e.is_err = is_err;
        e.d      = d;
        e.perr   = perr;
        exp_q.push_back(e);
    endtask

    task automatic drive_bit(input logic v, input int len);
        rx = v;
        repeat (len) @(negedge clk);
    endtask

    // rst_pos selects a data bit during which reset is pulsed (-1: none).
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int stop_len,
                              input logic par, input int rst_pos);
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 8; i++) begin
            if (i == rst_pos) begin
                rx = b[i];
                repeat (20) @(negedge clk);
                reset = 1'b0;
                #1;
                chk("rst_data", 32'(data), 32'h0);
                chk("rst_valid", 32'(valid), 32'h0);
                chk("rst_ferr", 32'(framing_err), 32'h0);
                chk("rst_busy", 32'(busy), 32'h0);
                repeat (3) @(negedge clk);
                reset = 1'b1;
                repeat (BIT - 23) @(negedge clk);
            end else begin
                drive_bit(b[i], BIT);
            end
        end
`ifdef UART_RX_PARITY_EN
        drive_bit(par, BIT);
`endif
        drive_bit(stop_v, stop_len);
        rx = 1'b1;
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && (valid || framing_err)) begin
                checks++;
                if (valid && framing_err) begin
                    errors++;
                    $display("FAIL mon_both: valid and framing_err high together at %0t", $time);
                end
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL mon_unexpected: valid=%b framing_err=%b with nothing expected at %0t",
                             valid, framing_err, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_ferr", 32'(framing_err), 32'(e.is_err));
                    chk("mon_valid", 32'(valid), 32'(!e.is_err));
                    chk("mon_busy", 32'(busy), 32'h0);
                    if (!e.is_err) chk("mon_data", 32'(data), 32'(e.d));
`ifdef UART_RX_PARITY_EN
                    chk("mon_perr", 32'(parity_err), 32'(e.perr));
`endif
                end
            end
        end
    end

    initial begin
        repeat (5) @(negedge clk);
        chk("reset_data", 32'(data), 32'h0);
        chk("reset_valid", 32'(valid), 32'h0);
        chk("reset_ferr", 32'(framing_err), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        reset = 1'b1;
        repeat (20) @(negedge clk);

        // Good frame 0xA5 (even parity bit = 0)
        push(1'b0, 8'hA5, 1'b0);
        send_frame(8'hA5, 1'b1, BIT, 1'b0, -1);
        drive_bit(1'b1, 100);
        chk("a5_data", 32'(data), 32'hA5);

        // Start glitch: low for 3 ticks
        drive_bit(1'b0, 8);
        chk("glitch_busy_hi", 32'(busy), 32'h1);
        drive_bit(1'b0, 4);
        drive_bit(1'b1, 100);
        chk("glitch_busy_lo", 32'(busy), 32'h0);
        chk("glitch_data", 32'(data), 32'hA5);

        // Framing error: 0x3C with low stop bit (parity 0)
        push(1'b1, 8'h00, 1'b0);
        send_frame(8'h3C, 1'b0, 44, 1'b0, -1);
        drive_bit(1'b1, 150);
        chk("ferr_data_hold", 32'(data), 32'hA5);
        chk("ferr_busy", 32'(busy), 32'h0);

        // Back-to-back 0x00 then 0xFF (both even parity 0)
        push(1'b0, 8'h00, 1'b0);
        push(1'b0, 8'hFF, 1'b0);
        send_frame(8'h00, 1'b1, BIT, 1'b0, -1);
        send_frame(8'hFF, 1'b1, BIT, 1'b0, -1);
        drive_bit(1'b1, 100);
        chk("b2b_data", 32'(data), 32'hFF);

        // Reset pulsed during bit 4 of 0xF8; remaining bits all high (parity 1)
        send_frame(8'hF8, 1'b1, BIT, 1'b1, 4);
        drive_bit(1'b1, 150);
        chk("rstfrm_data", 32'(data), 32'h0);
        chk("rstfrm_busy", 32'(busy), 32'h0);

`ifdef UART_RX_PARITY_EN
        // 0x01 with parity 0: odd count -> error; with parity 1: clean
        push(1'b0, 8'h01, 1'b1);
        send_frame(8'h01, 1'b1, BIT, 1'b0, -1);
        drive_bit(1'b1, 100);
        push(1'b0, 8'h01, 1'b0);
        send_frame(8'h01, 1'b1, BIT, 1'b1, -1);
        drive_bit(1'b1, 100);
        chk("par_data", 32'(data), 32'h01);
`endif

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
